// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock divider.
// Provides the default divisor width, the post-reset divisor and high time,
// the per-channel configuration record and the channel-index width helper.
package clk_div_pkg;

  localparam int CLK_DIV_DIV_W        = 16;
  localparam int CLK_DIV_DEFAULT_DIV  = 999;
  localparam int CLK_DIV_DEFAULT_HIGH = 500;

  // Divisor / high-time pair as held in the shadow and active registers.
  typedef struct packed {
    logic [CLK_DIV_DIV_W-1:0] div;
    logic [CLK_DIV_DIV_W-1:0] high;
  } ch_cfg_t;

  // Channel index width, never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active and shadow configuration,
// boundary-aligned apply of the shadow, registered level and tick outputs.
// Ports:
//   clk_in, rst        clock, synchronous active-high reset
//   en                 channel run enable
//   sync               global restart strobe
//   wr, wr_div, wr_high accepted config write for this channel
//   pending            shadow holds a value not yet applied
//   clk_out, tick      registered PWM level and period-start pulse
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int               DIV_W        = CLK_DIV_DIV_W,
  parameter logic [DIV_W-1:0] DEFAULT_DIV  = DIV_W'(CLK_DIV_DEFAULT_DIV),
  parameter logic [DIV_W-1:0] DEFAULT_HIGH = DIV_W'(CLK_DIV_DEFAULT_HIGH)
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  input  logic [DIV_W-1:0] wr_high,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] high_q, high_d;
  logic [DIV_W-1:0] sh_div_q, sh_high_q;
  logic             pend_q, pend_d;
  logic             run_q;
  logic             clk_q, tick_q;
  logic             wrap, restart, apply;

  always_comb begin
    wrap    = (cnt_q == div_q);
    // A fresh period starts on the natural wrap, on sync, or on the first
    // enabled edge after being stopped (run_q low), so enabling always
    // begins at cnt=0 with a tick.
    restart = sync | ~run_q | wrap;
    // While stopped every edge is a period boundary.
    apply   = ~en | restart;

    div_d  = div_q;
    high_d = high_q;
    if (apply && pend_q) begin
      div_d  = sh_div_q;
      high_d = sh_high_q;
    end

    // A write is only accepted while not pending, so it never coincides
    // with an apply that would clear the flag.
    if (wr) begin
      pend_d = 1'b1;
    end else if (apply) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end

    if (!en || restart) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q     <= '0;
      div_q     <= DEFAULT_DIV;
      high_q    <= DEFAULT_HIGH;
      sh_div_q  <= '0;
      sh_high_q <= '0;
      pend_q    <= 1'b0;
      run_q     <= 1'b0;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      high_q <= high_d;
      pend_q <= pend_d;
      run_q  <= en;
      if (wr) begin
        sh_div_q  <= wr_div;
        sh_high_q <= wr_high;
      end
      // Outputs follow the next-state counter so they move with cnt.
      clk_q  <= en & (cnt_d < high_d);
      tick_q <= en & (cnt_d == '0);
    end
  end

  assign pending = pend_q;
  assign clk_out = clk_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock-enable / PWM generator.
// Ports:
//   clk_in, rst              clock, synchronous active-high reset
//   en[NUM_CH]               per-channel run enable
//   sync                     restart all enabled channels in phase
//   cfg_valid/cfg_ch/cfg_div/cfg_high  config write request
//   cfg_ready                write accepted when high with cfg_valid
//   pending[NUM_CH]          shadow waiting to be applied
//   clk_out[NUM_CH]          registered divided level
//   tick[NUM_CH]             one-cycle pulse at each period start
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DIV_W        = CLK_DIV_DIV_W,
  parameter int DEFAULT_DIV  = CLK_DIV_DEFAULT_DIV,
  parameter int DEFAULT_HIGH = CLK_DIV_DEFAULT_HIGH,
  parameter int CH_W         = ch_w(NUM_CH)
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_high,
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] wr;

  // Out-of-range channel indices match nothing, so ready stays high and
  // the write falls on the floor.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(cfg_ch) == i) begin
        cfg_ready = ~pending[i];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign wr[gi] = cfg_valid & cfg_ready & (int'(cfg_ch) == gi);

    clk_div_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DIV_W'(DEFAULT_DIV)),
      .DEFAULT_HIGH(DIV_W'(DEFAULT_HIGH))
    ) u_chan (
      .clk_in (clk_in),
      .rst    (rst),
      .en     (en[gi]),
      .sync   (sync),
      .wr     (wr[gi]),
      .wr_div (cfg_div),
      .wr_high(cfg_high),
      .pending(pending[gi]),
      .clk_out(clk_out[gi]),
      .tick   (tick[gi])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scenario bench for clk_div_multi with a cycle-level reference model.
module tb_clk_div_multi;

  localparam int NCH = 4;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  en = 4'b0000;
  logic        sync = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [2:0]  cfg_ch = 3'd0;
  logic [15:0] cfg_div = 16'd0;
  logic [15:0] cfg_high = 16'd0;
  logic        cfg_ready;
  logic [3:0]  pending, clk_out, tick;

  int checks = 0;
  int errors = 0;

  // Reference model: position within the current period plus the
  // configuration in force, as described by the period rules.
  int m_run[NCH], m_pos[NCH], m_div[NCH], m_high[NCH];
  int m_pend[NCH], m_sdiv[NCH], m_shigh[NCH];
  bit m_clk[NCH], m_tick[NCH];

  clk_div_multi #(
    .NUM_CH(4), .DIV_W(16), .DEFAULT_DIV(999), .DEFAULT_HIGH(500), .CH_W(3)
  ) dut (
    .clk_in(clk_in), .rst(rst), .en(en), .sync(sync),
    .cfg_valid(cfg_valid), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_high(cfg_high),
    .cfg_ready(cfg_ready), .pending(pending), .clk_out(clk_out), .tick(tick)
  );

  always #5 clk_in = ~clk_in;

  function automatic bit model_ready();
    if (cfg_ch >= 3'(NCH)) return 1'b1;
    return (m_pend[cfg_ch] == 0);
  endfunction

  function automatic void model_edge();
    int xfer;
    bit bnd;
    xfer = -1;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_run[c] = 0; m_pos[c] = 0; m_div[c] = 999; m_high[c] = 500;
        m_pend[c] = 0; m_sdiv[c] = 0; m_shigh[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
      end
      return;
    end
    if (cfg_valid && model_ready() && cfg_ch < 3'(NCH)) xfer = int'(cfg_ch);
    for (int c = 0; c < NCH; c++) begin
      if (!en[c]) begin
        bnd = 1'b1;
        m_run[c] = 0; m_pos[c] = 0;
      end else begin
        bnd = (m_run[c] == 0) || sync || (m_pos[c] == m_div[c]);
        m_pos[c] = bnd ? 0 : m_pos[c] + 1;
        m_run[c] = 1;
      end
      if (bnd && m_pend[c] != 0) begin
        m_div[c] = m_sdiv[c]; m_high[c] = m_shigh[c]; m_pend[c] = 0;
      end
      m_tick[c] = en[c] && (m_pos[c] == 0);
      m_clk[c]  = en[c] && (m_pos[c] < m_high[c]);
      if (c == xfer) begin
        m_sdiv[c] = int'(cfg_div); m_shigh[c] = int'(cfg_high); m_pend[c] = 1;
      end
    end
  endfunction

  // {pending, clk_out, tick, cfg_ready} as the model predicts them.
  function automatic logic [12:0] exp_vec();
    logic [3:0] p, k, t;
    for (int c = 0; c < NCH; c++) begin
      p[c] = (m_pend[c] != 0); k[c] = m_clk[c]; t[c] = m_tick[c];
    end
    return {p, k, t, model_ready()};
  endfunction

  task automatic cyc();
    @(posedge clk_in);
    model_edge();
    #1;
  endtask

  task automatic cfg_write(input int ch, input int dv, input int hi);
    cfg_valid = 1'b1; cfg_ch = 3'(ch); cfg_div = 16'(dv); cfg_high = 16'(hi);
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if ({pending, clk_out, tick, cfg_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", i, {pending, clk_out, tick, cfg_ready}, exp_vec());
      end
    end
    rst = 1'b0;
    checks++;
    if ({pending, clk_out, tick, cfg_ready} !== 13'h0001) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", {pending, clk_out, tick, cfg_ready}, 13'h0001);
    end
  endtask

  task automatic test_defaults();
    int ticks, highs;
    ticks = 0; highs = 0;
    en = 4'b0001;
    for (int i = 0; i < 2000; i++) begin
      cyc();
      checks++;
      if ({pending, clk_out, tick, cfg_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL defaults cyc=%0d got=%h exp=%h", i, {pending, clk_out, tick, cfg_ready}, exp_vec());
      end
      ticks += int'(tick[0]);
      highs += int'(clk_out[0]);
    end
    checks++;
    if (ticks != 2 || highs != 1000) begin
      errors++;
      $display("FAIL defaults_shape ticks=%0d highs=%0d exp ticks=2 highs=1000", ticks, highs);
    end
  endtask

  task automatic test_program_ch1();
    int ticks, highs;
    ticks = 0; highs = 0;
    cfg_write(1, 9, 3);
    en = 4'b0011;
    for (int i = 0; i < 40; i++) begin
      cyc();
      checks++;
      if ({pending, clk_out, tick, cfg_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL program_ch1 cyc=%0d got=%h exp=%h", i, {pending, clk_out, tick, cfg_ready}, exp_vec());
      end
      if (i == 0) begin
        checks++;
        if (pending[1] !== 1'b0) begin
          errors++;
          $display("FAIL program_ch1_pend got=%b exp=0", pending[1]);
        end
      end
      ticks += int'(tick[1]);
      highs += int'(clk_out[1]);
    end
    checks++;
    if (ticks != 4 || highs != 12) begin
      errors++;
      $display("FAIL program_ch1_shape ticks=%0d highs=%0d exp ticks=4 highs=12", ticks, highs);
    end
  endtask

  task automatic test_mid_update();
    int t1, t2, highs;
    t1 = -1; t2 = -1; highs = 0;
    en = 4'b0010;
    cfg_write(0, 9, 5);
    cyc();
    en = 4'b0011;
    for (int i = 0; i < 4; i++) cyc();   // ch0 now at cnt=3
    cfg_write(0, 4, 2);
    checks++;
    if (pending[0] !== 1'b1 || cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_update_pend got=%b/%b exp=1/0", pending[0], cfg_ready);
    end
    for (int i = 0; i < 30; i++) begin
      cyc();
      checks++;
      if ({pending, clk_out, tick, cfg_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL mid_update cyc=%0d got=%h exp=%h", i, {pending, clk_out, tick, cfg_ready}, exp_vec());
      end
      if (tick[0] && t1 < 0) t1 = i;
      else if (tick[0] && t2 < 0) t2 = i;
      if (t1 >= 0 && t2 < 0) highs += int'(clk_out[0]);
    end
    checks++;
    if (t1 != 5 || t2 - t1 != 5 || highs != 2) begin
      errors++;
      $display("FAIL mid_update_shape t1=%0d period=%0d highs=%0d exp 5/5/2", t1, t2 - t1, highs);
    end
  endtask

  task automatic test_boundaries();
    bit ch0_hi, ch1_lo, ch2_notick;
    ch0_hi = 0; ch1_lo = 0; ch2_notick = 0;
    en = 4'b0000;
    cfg_write(0, 9, 0);
    cfg_write(1, 9, 12);
    cfg_write(2, 0, 1);
    cyc();
    en = 4'b0111;
    for (int i = 0; i < 25; i++) begin
      cyc();
      checks++;
      if ({pending, clk_out, tick, cfg_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL boundaries cyc=%0d got=%h exp=%h", i, {pending, clk_out, tick, cfg_ready}, exp_vec());
      end
      if (clk_out[0]) ch0_hi = 1;
      if (!clk_out[1]) ch1_lo = 1;
      if (!tick[2]) ch2_notick = 1;
    end
    checks++;
    if (ch0_hi || ch1_lo || ch2_notick) begin
      errors++;
      $display("FAIL boundaries_const got h0=%b l1=%b nt2=%b exp 0/0/0", ch0_hi, ch1_lo, ch2_notick);
    end
  endtask

  task automatic test_sync();
    en = 4'b0000;
    cfg_write(0, 9, 4);
    cfg_write(1, 4, 2);
    cyc();
    en = 4'b0001;
    repeat ($urandom_range(1, 9)) cyc();
    en = 4'b0011;
    repeat ($urandom_range(1, 9)) cyc();
    sync = 1'b1;
    cyc();
    sync = 1'b0;
    checks++;
    if (tick[2:0] !== 3'b011 || clk_out[2] !== 1'b0) begin
      errors++;
      $display("FAIL sync_align got tick=%b clk2=%b exp tick=011 clk2=0", tick[2:0], clk_out[2]);
    end
    for (int i = 0; i < 20; i++) begin
      cyc();
      checks++;
      if ({pending, clk_out, tick, cfg_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL sync cyc=%0d got=%h exp=%h", i, {pending, clk_out, tick, cfg_ready}, exp_vec());
      end
      if (i == 9 || i == 19) begin
        checks++;
        if (tick[1:0] !== 2'b11) begin
          errors++;
          $display("FAIL sync_realign cyc=%0d got=%b exp=11", i, tick[1:0]);
        end
      end
    end
  endtask

  task automatic test_handshake();
    bit seen;
    seen = 0;
    en = 4'b0001;
    cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 16'd7; cfg_high = 16'd3;
    cyc();
    cfg_div = 16'd5; cfg_high = 16'd1;
    for (int i = 0; i < 30 && !seen; i++) begin
      cyc();
      checks++;
      if ({pending, clk_out, tick, cfg_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL handshake cyc=%0d got=%h exp=%h", i, {pending, clk_out, tick, cfg_ready}, exp_vec());
      end
      if (cfg_ready) seen = 1;
    end
    checks++;
    if (!seen || tick[0] !== 1'b1) begin
      errors++;
      $display("FAIL handshake_apply got seen=%b tick0=%b exp 1/1", seen, tick[0]);
    end
    cyc();
    cfg_valid = 1'b0;
    checks++;
    if (pending[0] !== 1'b1) begin
      errors++;
      $display("FAIL handshake_accept got=%b exp=1", pending[0]);
    end
    cfg_valid = 1'b1; cfg_ch = 3'd5; cfg_div = 16'd1; cfg_high = 16'd1;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL handshake_oob_ready got=%b exp=1", cfg_ready);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if ({pending, clk_out, tick, cfg_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL handshake_oob cyc=%0d got=%h exp=%h", i, {pending, clk_out, tick, cfg_ready}, exp_vec());
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    en = 4'b1111;
    cfg_write(3, 6, 2);
    repeat ($urandom_range(3, 15)) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if ({pending, clk_out, tick, cfg_ready} !== 13'h0001) begin
      errors++;
      $display("FAIL reset_mid got=%h exp=%h", {pending, clk_out, tick, cfg_ready}, 13'h0001);
    end
    en = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      cyc();
      checks++;
      if ({pending, clk_out, tick, cfg_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL reset_mid_run cyc=%0d got=%h exp=%h", i, {pending, clk_out, tick, cfg_ready}, exp_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) en = 4'($urandom);
      sync      = ($urandom_range(0, 15) == 0);
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_ch    = 3'($urandom_range(0, 5));
      cfg_div   = 16'($urandom_range(0, 12));
      cfg_high  = 16'($urandom_range(0, 14));
      cyc();
      checks++;
      if ({pending, clk_out, tick, cfg_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", i, {pending, clk_out, tick, cfg_ready}, exp_vec());
      end
    end
    sync = 1'b0; cfg_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_program_ch1();
    test_mid_update();
    test_boundaries();
    test_sync();
    test_handshake();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
